// File: rtl/scan_unload_if.sv
// Handshake bundle for scan_unload: the parallel capture request plus the
// serial valid/ready stream and its status flags.
interface scan_unload_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             LOAD;
  logic             BUSY;
  logic             SO;
  logic             SV;
  logic             SR;
  logic             DONE;

  modport master (
    output D, LOAD, SR,
    input  BUSY, SO, SV, DONE
  );

  modport slave (
    input  D, LOAD, SR,
    output BUSY, SO, SV, DONE
  );
endinterface

// File: rtl/scan_unload.sv
// Parallel-capture, MSB-first serial unload engine with valid/ready handshake.
// Define SCAN_UNLOAD_PARITY_EN to append an even-parity bit to every frame.
module scan_unload #(
  parameter int WIDTH = 8
) (
  input  logic          C,
  input  logic          R,
  scan_unload_if.slave  bus
);

`ifdef SCAN_UNLOAD_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int            CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [FLEN-1:0] sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FLEN-1:0] capture_s;

`ifdef SCAN_UNLOAD_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    even_parity = ^v;
  endfunction

  // Parity rides in the LSB so it falls out of the MSB after the data bits.
  assign capture_s = {bus.D, even_parity(bus.D)};
`else
  assign capture_s = bus.D;
`endif

  // State, shift register and bit counter; synchronous active-low reset.
  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= ST_IDLE;
      sreg_q  <= {FLEN{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, capture and shift decisions.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.LOAD) begin
          sreg_d  = capture_s;
          cnt_d   = {CW{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.SR) begin
          sreg_d = {sreg_q[FLEN-2:0], 1'b0};
          cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state.
  always_comb begin
    bus.BUSY = 1'b0;
    bus.SV   = 1'b0;
    bus.SO   = 1'b0;
    bus.DONE = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        bus.BUSY = 1'b1;
        bus.SV   = 1'b1;
        bus.SO   = sreg_q[FLEN-1];
      end
      ST_DONE: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
      end
      default: begin
        bus.BUSY = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_unload.sv
// Scoreboard bench for scan_unload: expected serial bits are queued at capture
// time and popped by a monitor on every transfer cycle.
module tb_scan_unload;
  localparam int WIDTH = 8;
`ifdef SCAN_UNLOAD_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic C = 1'b0;
  logic R = 1'b0;
  scan_unload_if #(.WIDTH(WIDTH)) bus ();
  scan_unload #(.WIDTH(WIDTH)) dut (.C(C), .R(R), .bus(bus.slave));

  always #5 C = ~C;

  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  logic exp_q[$];
  logic mon_bit;

  task automatic push_frame(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SCAN_UNLOAD_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // Transfer monitor: every SV&SR cycle (outside reset) consumes one expected bit.
  always @(negedge C) begin
    if (R === 1'b1 && bus.SV === 1'b1 && bus.SR === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_bit: got SO=%b, required no transfer", bus.SO);
      end else begin
        mon_bit = exp_q.pop_front();
        if (bus.SO !== mon_bit) begin
          errors++;
          $display("FAIL so_bit: got %b, required %b", bus.SO, mon_bit);
        end
      end
    end
    if (bus.DONE === 1'b1) done_cnt++;
  end

  task automatic test_reset();
    logic [3:0] obs;
    R = 1'b0; bus.LOAD = 1'b1; bus.D = 8'hFF; bus.SR = 1'b1;
    repeat (3) @(posedge C);
    @(negedge C);
    obs = {bus.BUSY, bus.SV, bus.SO, bus.DONE};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b, required 0000", obs);
    end
    @(posedge C); #1;
    R = 1'b1; bus.LOAD = 1'b0;
    @(negedge C);
    obs = {bus.BUSY, bus.SV, bus.SO, bus.DONE};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL idle_hold: got %b, required 0000", obs);
    end
    @(posedge C); #1;
  endtask

  task automatic test_basic(input logic [WIDTH-1:0] d, input string name);
    logic [3:0] obs, exp;
    int d0 = done_cnt;
    push_frame(d);
    bus.D = d; bus.LOAD = 1'b1; bus.SR = 1'b1;
    @(posedge C); #1;
    bus.LOAD = 1'b0;
    for (int n = 1; n <= FL + 2; n++) begin
      @(negedge C);
      exp = {n <= FL + 1, n <= FL, n == FL + 1, 1'b0};
      obs = {bus.BUSY, bus.SV, bus.DONE, (n <= FL) ? 1'b0 : bus.SO};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL %s_status n=%0d: got %b, required %b", name, n, obs, exp);
      end
      @(posedge C); #1;
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL %s_end: got left=%0d dones=%0d, required 0 and 1", name, exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_sr_toggle();
    logic [2:0] obs, exp;
    int d0 = done_cnt;
    push_frame(8'hA5);
    bus.D = 8'hA5; bus.LOAD = 1'b1; bus.SR = 1'b1;
    @(posedge C); #1;
    bus.LOAD = 1'b0;
    for (int n = 1; n <= 2 * FL + 1; n++) begin
      bus.SR = (n % 2 == 1);
      @(negedge C);
      exp = {n <= 2 * FL, n <= 2 * FL - 1, n == 2 * FL};
      obs = {bus.BUSY, bus.SV, bus.DONE};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL toggle_status n=%0d: got %b, required %b", n, obs, exp);
      end
      if (bus.SR == 1'b0 && n < 2 * FL && exp_q.size() > 0) begin
        checks++;
        if (bus.SO !== exp_q[0]) begin
          errors++; $display("FAIL toggle_hold n=%0d: got %b, required %b", n, bus.SO, exp_q[0]);
        end
      end
      @(posedge C); #1;
    end
    bus.SR = 1'b1;
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL toggle_end: got left=%0d dones=%0d, required 0 and 1", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_load_ignored();
    logic [2:0] obs, exp;
    int d0 = done_cnt;
    push_frame(8'h00);
    bus.D = 8'h00; bus.LOAD = 1'b1; bus.SR = 1'b1;
    @(posedge C); #1;
    bus.D = 8'hFF;
    for (int n = 1; n <= FL + 2; n++) begin
      bus.LOAD = (n <= 4);
      @(negedge C);
      exp = {n <= FL + 1, n <= FL, n == FL + 1};
      obs = {bus.BUSY, bus.SV, bus.DONE};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL ignore_status n=%0d: got %b, required %b", n, obs, exp);
      end
      @(posedge C); #1;
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL ignore_end: got left=%0d dones=%0d, required 0 and 1", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] obs;
    int d0 = done_cnt;
    push_frame(8'hC3);
    bus.D = 8'hC3; bus.LOAD = 1'b1; bus.SR = 1'b1;
    @(posedge C); #1;
    bus.LOAD = 1'b0;
    repeat (3) begin
      @(posedge C); #1;
    end
    checks++;
    if (exp_q.size() != FL - 3) begin
      errors++; $display("FAIL mid_consumed: got left=%0d, required %0d", exp_q.size(), FL - 3);
    end
    R = 1'b0;
    @(posedge C);
    @(negedge C);
    obs = {bus.BUSY, bus.SV, bus.SO, bus.DONE};
    checks++;
    if (obs !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: got %b, required 0000", obs);
    end
    exp_q.delete();
    @(posedge C); #1;
    R = 1'b1;
    @(posedge C); #1;
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL mid_no_done: got dones=%0d, required 0", done_cnt - d0);
    end
    test_basic(8'h3C, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, exp;
    logic sv_e, dn_e;
    int d0 = done_cnt;
    push_frame(8'h96);
    bus.D = 8'h96; bus.LOAD = 1'b1; bus.SR = 1'b1;
    @(posedge C); #1;
    bus.D = 8'h4B;
    push_frame(8'h4B);
    for (int n = 1; n <= 2 * FL + 4; n++) begin
      if (n >= FL + 3) bus.LOAD = 1'b0;
      @(negedge C);
      sv_e = (n <= FL) || (n >= FL + 3 && n <= 2 * FL + 2);
      dn_e = (n == FL + 1) || (n == 2 * FL + 3);
      exp = {n != FL + 2 && n <= 2 * FL + 3, sv_e, dn_e};
      obs = {bus.BUSY, bus.SV, bus.DONE};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL b2b_status n=%0d: got %b, required %b", n, obs, exp);
      end
      @(posedge C); #1;
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 2) begin
      errors++;
      $display("FAIL b2b_end: got left=%0d dones=%0d, required 0 and 2", exp_q.size(), done_cnt - d0);
    end
  endtask

  initial begin
    bus.D = '0; bus.LOAD = 1'b0; bus.SR = 1'b0;
    test_reset();
    test_basic(8'hA5, "basic_a5");
    test_sr_toggle();
    test_load_ignored();
    test_reset_midframe();
    test_back_to_back();
`ifdef SCAN_UNLOAD_PARITY_EN
    test_basic(8'h07, "parity_07");
    test_basic(8'h03, "parity_03");
`else
    test_basic(8'h5A, "basic_5a");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_unload.md
SCAN_UNLOAD -- requirements
Module: scan_unload

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits captured and shifted out per frame (legal 2..32).
REQ-002 Port: C  input  1  clock; all state updates on posedge C.
REQ-003 Port: R  input  1  synchronous active-low reset, sampled on posedge C.
REQ-004 Port: D  input  WIDTH  parallel word to capture.
REQ-005 Port: LOAD  input  1  capture request; honoured only in IDLE.
REQ-006 Port: BUSY  output  1  high while a frame is held or shifting (SHIFT or DONE state).
REQ-007 Port: SO  output  1  serial data bit, MSB first.
REQ-008 Port: SV  output  1  serial valid; SO is meaningful when SV=1.
REQ-009 Port: SR  input  1  serial ready from consumer; a bit transfers on a cycle with SV=1 and SR=1.
REQ-010 Port: DONE  output  1  one-cycle pulse after the last bit of a frame transfers.

Function
REQ-011 States: IDLE, SHIFT, DONE; encoding is free; no other reachable states.
REQ-012 IDLE: if LOAD=1, capture D into the shift register, clear the bit counter, and go to SHIFT on the next edge; if LOAD=0, stay in IDLE.
REQ-013 LOAD asserted in SHIFT or DONE is ignored; no capture, no effect on the frame in progress.
REQ-014 SHIFT: SV=1 and SO=shift register MSB, both driven combinationally from registered state.
REQ-015 SHIFT, transfer cycle (SR=1): shift left by one, insert 0 at the LSB, increment the counter.
REQ-016 SHIFT, SR=0: register, counter and SO are held unchanged; there is no timeout.
REQ-017 Transfer of the final bit (counter = frame length - 1): next state DONE.
REQ-018 DONE: lasts exactly one cycle with DONE=1 and SV=0, then IDLE unconditionally.
REQ-019 Latency: LOAD sampled at edge k gives SV=1 from edge k+1; with SR held at 1, DONE=1 in cycle k+1+frame length; a new LOAD is accepted at edge k+2+frame length at the earliest.
REQ-020 BUSY=1 in SHIFT and DONE; BUSY=0 in IDLE.
REQ-021 SV=0 and SO=0 in IDLE and DONE.
REQ-022 Counter width is ceil(log2(WIDTH+2)) bits; it never wraps within a frame and clears on every capture.

Reset
REQ-023 With R=0 at a posedge C, next state is IDLE, shift register and counter are 0, and BUSY=0, SV=0, SO=0, DONE=0; this takes priority over LOAD and SR.
REQ-024 Reset asserted mid-frame abandons the frame with no DONE pulse; the first LOAD after R returns high starts a fresh frame.
REQ-025 No output changes other than on posedge C; no asynchronous paths from R.

Configuration
REQ-026 Macro SCAN_UNLOAD_PARITY_EN defined: frame length is WIDTH+1; after the WIDTH data bits, SO carries the even-parity bit (XOR of all captured D bits), computed at capture time and held with the frame.
REQ-027 Macro SCAN_UNLOAD_PARITY_EN undefined: frame length is WIDTH; no parity logic or parity register is present.

Verification
REQ-028 WIDTH=8, no parity; LOAD=1 with D=8'hA5, SR=1 continuously -> SO sequence 1,0,1,0,0,1,0,1 on 8 consecutive SV cycles; DONE pulse one cycle after the 8th bit; BUSY=0 next cycle.
REQ-029 Same frame with SR toggling 1,0,1,0,... -> SO and SV held through SR=0 cycles; the bit sequence is unchanged; DONE occurs after 8 transfers (16 cycles).
REQ-030 LOAD=1 with D=8'hFF during SHIFT of frame 8'h00 -> the consumer receives eight 0 bits; no recapture; BUSY stays 1 until DONE.
REQ-031 R=0 after the 3rd bit of 8'hC3 -> next cycle SV=0, BUSY=0, DONE never pulses; a following LOAD with D=8'h3C delivers 0,0,1,1,1,1,0,0.
REQ-032 PARITY_EN defined, D=8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1; D=8'h03 -> 9th bit 0; DONE follows the 9th transfer.
REQ-033 LOAD=1 held continuously, SR=1 -> frames back-to-back with exactly one DONE cycle and one IDLE capture cycle between the last bit of one frame and the first bit of the next.
